hub75_bcm_scheduler: RTL and testbench

- Sequences the HUB75 panel output strobes for binary-code-modulated (BCM) display: blank (OE), latch (LAT) and row address.
- Sits between the row-transmit control FSM / shift-register datapath and the panel pins.
- Each loaded bit-plane line is latched and displayed for (base_time+1)·2^pix_bit clocks.
- Reports blanking back to the control FSM, which uses its rising edge to start the next line transfer; flags underrun/overflow.

---
 rtl/hub75_bcm_scheduler.sv | 181 ++++++++++++++++++
 tb/tb_hub75_bcm_scheduler.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hub75_bcm_scheduler.sv
// HUB75 BCM strobe scheduler: sequences blank/latch/row-address around each
// bit-plane line and holds OE low for (base_time+1)*2^pix_bit clocks.
module hub75_bcm_scheduler #(
    parameter  int vpixel_p     = 64,
    parameter  int segments_p   = 2,
    parameter  int bpp_p        = 8,
    parameter  int clk_div_wd_p = 8,
    parameter  int dead_time_p  = 2,
    localparam int row_wd       = $clog2(vpixel_p / segments_p),
    localparam int bit_wd       = $clog2(bpp_p),
    localparam int on_wd        = clk_div_wd_p + bpp_p
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_enable,
    input  logic                    i_line_ready,
    input  logic [bit_wd-1:0]       i_pix_bit,
    input  logic [row_wd-1:0]       i_row,
    input  logic [clk_div_wd_p-1:0] i_base_time,
    output logic                    o_lat,
    output logic                    o_oe_n,
    output logic [row_wd-1:0]       o_row_addr,
    output logic                    o_blanking,
    output logic                    o_underrun,
    output logic                    o_overflow
);

    localparam int dt_wd = $clog2(dead_time_p + 1);
    localparam logic [dt_wd-1:0] dt_last = dt_wd'(dead_time_p - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE,
        ST_LATCH,
        ST_POST,
        ST_DISPLAY,
        ST_WAIT
    } state_t;

    state_t              state_q, state_d;
    logic [dt_wd-1:0]    dt_q, dt_d;
    logic [on_wd-1:0]    on_q, on_d;
    logic                pend_q, pend_d;
    logic [row_wd-1:0]   pend_row_q, pend_row_d;
    logic [bit_wd-1:0]   pend_bit_q, pend_bit_d;
    logic [row_wd-1:0]   row_addr_q, row_addr_d;
    logic                lat_q, lat_d;
    logic                oe_n_q, oe_n_d;
    logic                blank_q, blank_d;
    logic                underrun_q, underrun_d;
    logic                overflow_q, overflow_d;
    logic                consume;
    logic [on_wd-1:0]    base_ext;
    logic [on_wd-1:0]    on_val;

    // Plane on-time is computed at full width so the largest plane cannot wrap.
    assign base_ext = {{bpp_p{1'b0}}, i_base_time};
    assign on_val   = (base_ext + on_wd'(1)) << pend_bit_q;
    assign consume  = (state_q == ST_LATCH);

    always_comb begin
        state_d    = state_q;
        dt_d       = dt_q;
        on_d       = on_q;
        pend_d     = pend_q;
        pend_row_d = pend_row_q;
        pend_bit_d = pend_bit_q;
        row_addr_d = row_addr_q;
        underrun_d = underrun_q;
        overflow_d = overflow_q;

        if (!i_enable) begin
            state_d = ST_IDLE;
            pend_d  = 1'b0;
            dt_d    = '0;
        end else begin
            if (consume) begin
                pend_d = 1'b0;
            end
            // A pulse landing on the latch cycle refills the slot it just freed.
            if (i_line_ready) begin
                if (pend_q && !consume) begin
                    overflow_d = 1'b1;
                end else begin
                    pend_d     = 1'b1;
                    pend_row_d = i_row;
                    pend_bit_d = i_pix_bit;
                end
            end

            case (state_q)
                ST_IDLE, ST_WAIT: begin
                    if (pend_d) begin
                        state_d = ST_PRE;
                        dt_d    = '0;
                    end
                end
                ST_PRE: begin
                    if (dt_q == dt_last) begin
                        state_d    = ST_LATCH;
                        dt_d       = '0;
                        row_addr_d = pend_row_q;
                    end else begin
                        dt_d = dt_q + dt_wd'(1);
                    end
                end
                ST_LATCH: begin
                    on_d    = on_val;
                    state_d = ST_POST;
                    dt_d    = '0;
                end
                ST_POST: begin
                    if (dt_q == dt_last) begin
                        state_d = ST_DISPLAY;
                        dt_d    = '0;
                    end else begin
                        dt_d = dt_q + dt_wd'(1);
                    end
                end
                ST_DISPLAY: begin
                    if (on_q == on_wd'(1)) begin
                        if (pend_d) begin
                            state_d = ST_PRE;
                        end else begin
                            state_d    = ST_WAIT;
                            underrun_d = 1'b1;
                        end
                        dt_d = '0;
                    end else begin
                        on_d = on_q - on_wd'(1);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        lat_d   = (state_d == ST_LATCH);
        oe_n_d  = (state_d != ST_DISPLAY);
        blank_d = oe_n_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            dt_q       <= '0;
            on_q       <= '0;
            pend_q     <= 1'b0;
            pend_row_q <= '0;
            pend_bit_q <= '0;
            row_addr_q <= '0;
            lat_q      <= 1'b0;
            oe_n_q     <= 1'b1;
            blank_q    <= 1'b1;
            underrun_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            dt_q       <= dt_d;
            on_q       <= on_d;
            pend_q     <= pend_d;
            pend_row_q <= pend_row_d;
            pend_bit_q <= pend_bit_d;
            row_addr_q <= row_addr_d;
            lat_q      <= lat_d;
            oe_n_q     <= oe_n_d;
            blank_q    <= blank_d;
            underrun_q <= underrun_d;
            overflow_q <= overflow_d;
        end
    end

    assign o_lat      = lat_q;
    assign o_oe_n     = oe_n_q;
    assign o_row_addr = row_addr_q;
    assign o_blanking = blank_q;
    assign o_underrun = underrun_q;
    assign o_overflow = overflow_q;

endmodule

// File: tb/tb_hub75_bcm_scheduler.sv
// Scoreboard bench for hub75_bcm_scheduler: stimulus queues expected latch
// row / OE-low width / latch spacing, a negedge monitor checks each latch.
module tb_hub75_bcm_scheduler;

    localparam int D = 2;

    logic       clk;
    logic       rst_n;
    logic       i_enable;
    logic       i_line_ready;
    logic [2:0] i_pix_bit;
    logic [4:0] i_row;
    logic [7:0] i_base_time;
    logic       o_lat;
    logic       o_oe_n;
    logic [4:0] o_row_addr;
    logic       o_blanking;
    logic       o_underrun;
    logic       o_overflow;

    hub75_bcm_scheduler #(
        .vpixel_p    (64),
        .segments_p  (2),
        .bpp_p       (8),
        .clk_div_wd_p(8),
        .dead_time_p (D)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_enable    (i_enable),
        .i_line_ready(i_line_ready),
        .i_pix_bit   (i_pix_bit),
        .i_row       (i_row),
        .i_base_time (i_base_time),
        .o_lat       (o_lat),
        .o_oe_n      (o_oe_n),
        .o_row_addr  (o_row_addr),
        .o_blanking  (o_blanking),
        .o_underrun  (o_underrun),
        .o_overflow  (o_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int row;
        int width;
        int gap;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   mon_phase = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: pops one expectation per latch, then times latch-to-OE and OE-low width.
    exp_t cur;
    int   gap_cnt, width_cnt, last_lat;
    initial last_lat = 0;
    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            mon_phase = 0;
        end else begin
            case (mon_phase)
                1: begin
                    gap_cnt++;
                    if (!o_oe_n) begin
                        checkOutput("lat_to_oe_fall", gap_cnt, D + 1);
                        checkOutput("blanking_fall", {31'b0, o_blanking}, 0);
                        width_cnt = 1;
                        mon_phase = 2;
                    end
                end
                2: begin
                    if (o_oe_n) begin
                        if (cur.width != 0) checkOutput("oe_low_width", width_cnt, cur.width);
                        checkOutput("blanking_rise", {31'b0, o_blanking}, 1);
                        mon_phase = 0;
                    end else begin
                        width_cnt++;
                    end
                end
                default: ;
            endcase
            if (o_lat) begin
                if (sb.size() == 0) begin
                    checkOutput("unexpected_lat", {31'b0, o_lat}, 0);
                end else begin
                    cur = sb.pop_front();
                    checkOutput("row_addr", {27'b0, o_row_addr}, cur.row);
                    if (cur.gap != 0) checkOutput("lat_spacing", cyc - last_lat, cur.gap);
                    gap_cnt   = 0;
                    mon_phase = 1;
                end
                last_lat = cyc;
            end
        end
    end

    task automatic applyStimulus(input int row, input int pbit, input int width, input int gap,
                                 input bit do_push, input bit check_lat);
        int k;
        bit seen;
        if (do_push) sb.push_back('{row, width, gap});
        i_row        = 5'(row);
        i_pix_bit    = 3'(pbit);
        i_line_ready = 1'b1;
        if (check_lat) begin
            k = 0;
            seen = 1'b0;
            while (!seen && k < 20) begin
                @(negedge clk);
                k++;
                if (k == 1) i_line_ready = 1'b0;
                if (o_lat) seen = 1'b1;
            end
            checkOutput("lat_latency", seen ? k : 0, D + 1);
        end else begin
            @(negedge clk);
            i_line_ready = 1'b0;
        end
    endtask

    task automatic wait_oe_fall();
        int k = 0;
        while (o_oe_n == 1'b0 && k < 70000) begin @(negedge clk); k++; end
        while (o_oe_n == 1'b1 && k < 70000) begin @(negedge clk); k++; end
        if (k >= 70000) checkOutput("oe_fall_timeout", k, 0);
    endtask

    task automatic wait_done();
        int k = 0;
        do begin
            @(negedge clk);
            #1;
            k++;
        end while (!(sb.size() == 0 && mon_phase == 0) && k < 70000);
        if (k >= 70000) checkOutput("done_timeout", k, 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #3000000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst_n        = 1'b0;
        i_enable     = 1'b1;
        i_line_ready = 1'b0;
        i_pix_bit    = '0;
        i_row        = '0;
        i_base_time  = 8'd3;
        repeat (2) @(negedge clk);
        checkOutput("rst_oe_n", {31'b0, o_oe_n}, 1);
        checkOutput("rst_blanking", {31'b0, o_blanking}, 1);
        checkOutput("rst_lat", {31'b0, o_lat}, 0);
        checkOutput("rst_row", {27'b0, o_row_addr}, 0);
        checkOutput("rst_underrun", {31'b0, o_underrun}, 0);
        checkOutput("rst_overflow", {31'b0, o_overflow}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] single plane row 5 bit 2 base 3");
        applyStimulus(5, 2, 16, 0, 1'b1, 1'b1);
        checkOutput("underrun_first_entry", {31'b0, o_underrun}, 0);
        wait_done();

        $display("[TB] back-to-back planes 0..7 base 0");
        do_reset();
        i_base_time = 8'd0;
        applyStimulus(0, 0, 1, 0, 1'b1, 1'b1);
        for (int b = 1; b < 8; b++) begin
            wait_oe_fall();
            applyStimulus(b, b, 1 << b, (1 << (b - 1)) + 2 * D + 1, 1'b1, 1'b0);
        end
        wait_oe_fall();
        checkOutput("planes_underrun", {31'b0, o_underrun}, 0);
        checkOutput("planes_overflow", {31'b0, o_overflow}, 0);
        wait_done();

        $display("[TB] underrun then resume from WAIT");
        repeat (5) @(negedge clk);
        checkOutput("wait_oe_n", {31'b0, o_oe_n}, 1);
        checkOutput("wait_underrun", {31'b0, o_underrun}, 1);
        applyStimulus(9, 1, 2, 0, 1'b1, 1'b1);
        wait_done();

        $display("[TB] overflow during display");
        i_base_time = 8'd3;
        checkOutput("pre_overflow", {31'b0, o_overflow}, 0);
        applyStimulus(3, 3, 32, 0, 1'b1, 1'b1);
        wait_oe_fall();
        applyStimulus(7, 1, 8, 32 + 2 * D + 1, 1'b1, 1'b0);
        @(negedge clk);
        applyStimulus(12, 0, 0, 0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("overflow_set", {31'b0, o_overflow}, 1);
        wait_done();

        $display("[TB] enable dropped mid-display");
        i_base_time = 8'd255;
        applyStimulus(20, 7, 0, 0, 1'b1, 1'b1);
        wait_oe_fall();
        repeat (10) @(negedge clk);
        applyStimulus(1, 0, 0, 0, 1'b0, 1'b0);
        i_enable = 1'b0;
        @(negedge clk);
        checkOutput("dis_oe_n", {31'b0, o_oe_n}, 1);
        checkOutput("dis_lat", {31'b0, o_lat}, 0);
        checkOutput("dis_row_held", {27'b0, o_row_addr}, 20);
        applyStimulus(6, 0, 0, 0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        i_enable = 1'b1;
        repeat (8) @(negedge clk);
        checkOutput("reen_oe_n", {31'b0, o_oe_n}, 1);
        i_base_time = 8'd0;
        applyStimulus(2, 0, 1, 0, 1'b1, 1'b1);
        wait_done();

        $display("[TB] async reset mid-display");
        i_base_time = 8'd255;
        applyStimulus(30, 7, 0, 0, 1'b1, 1'b1);
        wait_oe_fall();
        repeat (5) @(negedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("arst_oe_n", {31'b0, o_oe_n}, 1);
        checkOutput("arst_blanking", {31'b0, o_blanking}, 1);
        checkOutput("arst_lat", {31'b0, o_lat}, 0);
        checkOutput("arst_row", {27'b0, o_row_addr}, 0);
        checkOutput("arst_underrun", {31'b0, o_underrun}, 0);
        checkOutput("arst_overflow", {31'b0, o_overflow}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        i_base_time = 8'd0;
        @(negedge clk);
        applyStimulus(4, 1, 2, 0, 1'b1, 1'b1);
        wait_done();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
